// File: rtl/exec_issue.sv
// exec_issue: 3-state issue/writeback controller for the 16-bit alu; define EXEC_ISSUE_ADDC_EN to enable ADDC (reg 0x07 / imm op 0x7)
module exec_issue (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [7:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_cin,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        done,
  output logic        illegal_op,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
`ifdef EXEC_ISSUE_ADDC_EN
  localparam logic ADDC = 1'b1;
`else
  localparam logic ADDC = 1'b0;
`endif
  state_t      state, nxt;
  logic [15:0] ir, res, imm;
  logic [15:0] rf [16];
  logic [4:0]  flg, psr_q;
  logic [7:0]  code, dec_op;
  logic        ill, reg_form, addc, sext, wr_reg, wr_psr;
  function automatic logic legal_f(input logic [15:0] w);
    logic [7:0] c;
    c = {w[15:12], w[7:4]};
    return (w[15:12] == 4'h0 || w[15:12] == 4'h8)
      ? ((c inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0B,
                    8'h0C, 8'h0D, 8'h0E, 8'h84, 8'h86}) || (ADDC && c == 8'h07))
      : ((w[15:12] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hC, 4'hD})
         || (ADDC && w[15:12] == 4'h7));
  endfunction
  assign code     = {ir[15:12], ir[7:4]};
  assign reg_form = ir[15:12] == 4'h0 || ir[15:12] == 4'h8;
  assign addc     = ADDC && (reg_form ? code == 8'h07 : ir[15:12] == 4'h7);
  assign sext     = ir[15:12] inside {4'h5, 4'h7, 4'h9, 4'hC, 4'hD};
  assign imm      = sext ? {{8{ir[7]}}, ir[7:0]} : {8'h00, ir[7:0]};
  // ADDC reuses the ADD opcode; only the carry-in differs
  assign dec_op   = addc ? 8'h05 : reg_form ? code : {4'h0, ir[15:12]};
  assign wr_reg   = !ill && !(dec_op inside {8'h00, 8'h0B, 8'h0C});
  assign wr_psr   = !ill && !(dec_op inside {8'h00, 8'h0D});
  assign instr_ready = state == IDLE;
  assign done        = state == WB;
  assign illegal_op  = state == WB && ill;
  assign alu_op      = state == EXEC ? dec_op : 8'h00;
  assign alu_a       = state == EXEC ? rf[ir[11:8]] : 16'h0000;
  assign alu_b       = state == EXEC ? (reg_form ? rf[ir[3:0]] : imm) : 16'h0000;
  assign alu_cin     = state == EXEC && addc && psr_q[0];
  assign psr         = psr_q;
  assign dbg_data    = rf[dbg_addr];
  always_comb begin
    nxt = IDLE;
    nxt = state == IDLE ? (instr_valid ? (legal_f(instr) ? EXEC : WB) : IDLE)
        : state == EXEC ? WB : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ir    <= '0;
      ill   <= 1'b0;
      res   <= '0;
      flg   <= '0;
      psr_q <= '0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      if (state == IDLE && instr_valid) begin
        ir  <= instr;
        ill <= !legal_f(instr);
      end
      if (state == EXEC) begin
        res <= alu_result;
        flg <= alu_flags;
      end
      if (state == WB && wr_reg) rf[ir[11:8]] <= res;
      if (state == WB && wr_psr) psr_q <= flg;
    end
endmodule

// File: tb/tb_exec_issue.sv
// tb_exec_issue: directed scoreboard bench for exec_issue with a small behavioural alu
module tb_exec_issue;
  logic        clk = 0, reset_n = 0, instr_valid = 0, instr_ready, alu_cin, done, illegal_op;
  logic [15:0] instr = 0, alu_a, alu_b, alu_result, dbg_data;
  logic [7:0]  alu_op;
  logic [4:0]  alu_flags, psr;
  logic [3:0]  dbg_addr = 0;
  int checks = 0, errors = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] b;
    logic        cin;
    logic [3:0]  idx;
    logic [15:0] val;
    logic [4:0]  p;
    logic        il;
  } exp_t;
  exp_t sb [$];

  exec_issue dut (
    .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_flags(alu_flags), .psr(psr),
    .done(done), .illegal_op(illegal_op), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // behavioural alu: flags {NEG, ZERO, OVF, LOW(signed a<b), CARRY/borrow}
  always_comb begin
    logic [16:0] s;
    logic v, lo, c;
    s = '0; v = 0; lo = 0; c = 0;
    alu_result = 16'h0000;
    case (alu_op)
      8'h01: alu_result = alu_a & alu_b;
      8'h02: alu_result = alu_a | alu_b;
      8'h03: alu_result = alu_a ^ alu_b;
      8'h05: begin
        s = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
        alu_result = s[15:0];
        c = s[16];
        v = (alu_a[15] == alu_b[15]) && (s[15] != alu_a[15]);
      end
      8'h06, 8'h0B, 8'h0C: begin
        alu_result = alu_a - alu_b;
        c = alu_a < alu_b;
        v = (alu_a[15] != alu_b[15]) && (alu_result[15] != alu_a[15]);
        lo = $signed(alu_a) < $signed(alu_b);
      end
      8'h0D: alu_result = alu_b;
      8'h84: alu_result = alu_a << alu_b[3:0];
      default: alu_result = 16'h0000;
    endcase
    alu_flags = {alu_result[15], alu_result == 16'h0000, v, lo, c};
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] x);
    checks++;
    assert (o === x) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, x);
    end
  endtask

  task automatic issue(input logic [15:0] w, input logic [7:0] eop, input logic [15:0] eb,
                       input logic ec, input logic [3:0] idx, input logic [15:0] val,
                       input logic [4:0] p, input logic il);
    exp_t e;
    int lat;
    sb.push_back('{eop, eb, ec, idx, val, p, il});
    @(negedge clk);
    instr = w; instr_valid = 1; dbg_addr = idx;
    chk("ready_before_accept", instr_ready, 1);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0; instr = 16'(($urandom));
    if (!sb[0].il) begin
      chk("exec_alu_op", alu_op, sb[0].op);
      chk("exec_alu_b", alu_b, sb[0].b);
      chk("exec_alu_cin", alu_cin, sb[0].cin);
      chk("exec_not_ready", instr_ready, 0);
    end
    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    chk("done_latency", lat, e.il ? 1 : 2);
    chk("illegal_op", illegal_op, e.il);
    @(negedge clk);
    chk("rf_value", dbg_data, e.val);
    chk("psr", psr, e.p);
    chk("done_one_cycle", done, 0);
    chk("ready_after_wb", instr_ready, 1);
    chk("idle_alu_op", alu_op, 0);
    chk("idle_alu_a", alu_a, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal_op, 0);
    chk("rst_psr", psr, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_cin", alu_cin, 0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1 chk("rst_rf", dbg_data, 0);
    end
    reset_n = 1;
    //     instr     op     b        cin idx  value    psr    ill
    issue(16'hD17F, 8'h0D, 16'h007F, 0, 1, 16'h007F, 5'h00, 0);
    issue(16'hD1FF, 8'h0D, 16'hFFFF, 0, 1, 16'hFFFF, 5'h00, 0);
    issue(16'hD801, 8'h0D, 16'h0001, 0, 8, 16'h0001, 5'h00, 0);
    issue(16'hD90F, 8'h0D, 16'h000F, 0, 9, 16'h000F, 5'h00, 0);
    issue(16'h8849, 8'h84, 16'h000F, 0, 8, 16'h8000, 5'h10, 0);
    issue(16'h0138, 8'h03, 16'h8000, 0, 1, 16'h7FFF, 5'h00, 0);
    issue(16'hD201, 8'h0D, 16'h0001, 0, 2, 16'h0001, 5'h00, 0);
    issue(16'h0152, 8'h05, 16'h0001, 0, 1, 16'h8000, 5'h14, 0);
    issue(16'h01C2, 8'h0C, 16'h0001, 0, 1, 16'h8000, 5'h06, 0);
    issue(16'h53FF, 8'h05, 16'hFFFF, 0, 3, 16'hFFFF, 5'h10, 0);
    issue(16'hDA85, 8'h0D, 16'hFF85, 0, 10, 16'hFF85, 5'h10, 0);
    issue(16'h13FF, 8'h01, 16'h00FF, 0, 3, 16'h00FF, 5'h00, 0);
    issue(16'h0000, 8'h00, 16'h0000, 0, 0, 16'h0000, 5'h00, 0);
    issue(16'hF000, 8'h00, 16'h0000, 0, 0, 16'h0000, 5'h00, 1);
    issue(16'h0140, 8'h00, 16'h0000, 0, 1, 16'h8000, 5'h00, 1);
    issue(16'h4123, 8'h00, 16'h0000, 0, 1, 16'h8000, 5'h00, 1);
`ifdef EXEC_ISSUE_ADDC_EN
    issue(16'hD6FF, 8'h0D, 16'hFFFF, 0, 6, 16'hFFFF, 5'h00, 0);
    issue(16'hD701, 8'h0D, 16'h0001, 0, 7, 16'h0001, 5'h00, 0);
    issue(16'h0657, 8'h05, 16'h0001, 0, 6, 16'h0000, 5'h09, 0);
    issue(16'hD601, 8'h0D, 16'h0001, 0, 6, 16'h0001, 5'h09, 0);
    issue(16'h0677, 8'h05, 16'h0001, 1, 6, 16'h0003, 5'h00, 0);
`else
    issue(16'hD601, 8'h0D, 16'h0001, 0, 6, 16'h0001, 5'h00, 0);
    issue(16'hD701, 8'h0D, 16'h0001, 0, 7, 16'h0001, 5'h00, 0);
    issue(16'h0677, 8'h00, 16'h0000, 0, 6, 16'h0001, 5'h00, 1);
    issue(16'h7612, 8'h00, 16'h0000, 0, 6, 16'h0001, 5'h00, 1);
`endif
    issue(16'hD503, 8'h0D, 16'h0003, 0, 5, 16'h0003, psr, 0);
    @(negedge clk);
    instr = 16'h0455; instr_valid = 1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 0;
    chk("pre_reset_exec_op", alu_op, 8'h05);
    reset_n = 0;
    #1;
    chk("mid_reset_ready", instr_ready, 1);
    chk("mid_reset_done", done, 0);
    @(negedge clk);
    reset_n = 1;
    dbg_addr = 4;
    #1 chk("reset_r4", dbg_data, 0);
    dbg_addr = 5;
    #1 chk("reset_r5", dbg_data, 0);
    chk("reset_psr", psr, 0);
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_reset", done, 0);
      chk("idle_after_reset", instr_ready, 1);
    end
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
